// File: rtl/nios_rs232_tx.sv
// Avalon-MM UART transmitter: 4-register slave, byte FIFO, 8N1 serializer with programmable divisor.
// Optional parity bit (8E1/8O1) when NIOS_RS232_TX_PARITY_EN is defined.
module nios_rs232_tx #(
  parameter int unsigned DIV_RESET  = 434,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_d;
  logic [DIV_WIDTH-1:0] div_reg, div_lat, div_lat_d, baud_cnt, baud_cnt_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic [7:0]           shifter, shifter_d;
  logic                 irq_en, overflow, txd_d, pop, period_end;
  logic                 wr_en, push, full, empty;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [31:0]          status, rd_mux;
  logic                 unused_wdata;
`ifdef NIOS_RS232_TX_PARITY_EN
  logic                 par_en, par_odd, par_acc, par_acc_d;
`endif

  assign wr_en        = chipselect & ~write_n;
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign push         = wr_en && (address == 2'd0) && !full;
  assign period_end   = (baud_cnt == div_lat - DIV_WIDTH'(1));
  assign unused_wdata = ^writedata;

  // Control/status registers; a push to a full FIFO is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg  <= DIV_WIDTH'(DIV_RESET);
      irq_en   <= 1'b0;
      overflow <= 1'b0;
`ifdef NIOS_RS232_TX_PARITY_EN
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
`endif
    end else begin
      if (wr_en && (address == 2'd0) && full) overflow <= 1'b1;
      if (wr_en && (address == 2'd1)) begin
        if (writedata[3]) overflow <= 1'b0;
        irq_en <= writedata[4];
`ifdef NIOS_RS232_TX_PARITY_EN
        par_en  <= writedata[5];
        par_odd <= writedata[6];
`endif
      end
      if (wr_en && (address == 2'd2))
        div_reg <= (writedata[DIV_WIDTH-1:0] < DIV_WIDTH'(2)) ? DIV_WIDTH'(2)
                                                              : writedata[DIV_WIDTH-1:0];
    end
  end

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      div_lat  <= DIV_WIDTH'(DIV_RESET);
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      txd      <= 1'b1;
`ifdef NIOS_RS232_TX_PARITY_EN
      par_acc  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      div_lat  <= div_lat_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shifter  <= shifter_d;
      txd      <= txd_d;
`ifdef NIOS_RS232_TX_PARITY_EN
      par_acc  <= par_acc_d;
`endif
    end
  end

  // Next state; txd is decoded from the next state so the flop tracks the state with no lag.
  always_comb begin
    state_d    = state;
    div_lat_d  = div_lat;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shifter_d  = shifter;
    pop        = 1'b0;
    txd_d      = 1'b1;
`ifdef NIOS_RS232_TX_PARITY_EN
    par_acc_d  = par_acc;
`endif
    if (state != S_IDLE) baud_cnt_d = period_end ? '0 : baud_cnt + DIV_WIDTH'(1);
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (period_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (period_end) begin
          shifter_d = {1'b0, shifter[7:1]};
          bit_idx_d = bit_idx + 3'd1;
`ifdef NIOS_RS232_TX_PARITY_EN
          par_acc_d = par_acc ^ shifter[0];
          if (bit_idx == 3'd7) state_d = par_en ? S_PARITY : S_STOP;
`else
          if (bit_idx == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef NIOS_RS232_TX_PARITY_EN
      S_PARITY: begin
        if (period_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (period_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Divisor is captured at each frame start so mid-frame DIV writes only affect later frames.
    if (pop) begin
      shifter_d  = mem[rd_ptr];
      div_lat_d  = div_reg;
      baud_cnt_d = '0;
`ifdef NIOS_RS232_TX_PARITY_EN
      par_acc_d  = 1'b0;
`endif
    end
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shifter_d[0];
`ifdef NIOS_RS232_TX_PARITY_EN
      S_PARITY: txd_d = par_acc_d ^ par_odd;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    status    = '0;
    status[0] = (state != S_IDLE);
    status[1] = full;
    status[2] = empty;
    status[3] = overflow;
    status[4] = irq_en;
`ifdef NIOS_RS232_TX_PARITY_EN
    status[5] = par_en;
    status[6] = par_odd;
`endif
    status[8 +: CNT_W] = count;
    case (address)
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = 32'(div_reg);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_en & empty;
    end
  end

endmodule

// File: tb/tb_nios_rs232_tx.sv
// Scoreboard bench for nios_rs232_tx: read and frame expectations are queued by the stimulus
// and consumed by independent monitors on the read port and on txd.
module tb_nios_rs232_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        chipselect;
  logic [31:0] readdata;
  logic        txd;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         par_en;
    bit         odd;
    bit         contig;
  } frm_t;

  frm_t        tx_q[$];
  logic [31:0] rd_exp[$];
  string       rd_name[$];
  logic        rd_req = 1'b0;
  logic        rd_due = 1'b0;

  nios_rs232_tx #(.DIV_RESET(434), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write_n(write_n),
    .writedata(writedata), .chipselect(chipselect), .readdata(readdata),
    .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_due <= rd_req;

  // Read monitor: readdata is valid the cycle after the address was presented.
  always @(negedge clk) begin
    if (rd_due) begin
      checks++;
      if (rd_exp.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=0x%08h required a queued expectation", readdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = rd_exp.pop_front();
        n = rd_name.pop_front();
        if (readdata !== e) begin
          failures++;
          $display("FAIL %s got=0x%08h required=0x%08h", n, readdata, e);
        end
      end
    end
  end

  // Frame monitor: every cycle of a frame is compared against the expected bit sequence.
  initial begin : tx_monitor
    frm_t        f;
    logic [10:0] bits;
    int          nb, bad, start_cyc, last_end, prev_end;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && txd === 1'b0) begin
        start_cyc = cyc;
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected_start cyc=%0d got txd=0 required idle 1", cyc);
          for (int i = 0; i < 4000 && txd !== 1'b1; i++) @(negedge clk);
        end else begin
          f = tx_q.pop_front();
          bits = '0;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = f.d[i];
          if (f.par_en) begin
            bits[9]  = (^f.d) ^ f.odd;
            bits[10] = 1'b1;
            nb = 11;
          end else begin
            bits[9] = 1'b1;
            nb = 10;
          end
          bad = 0;
          if (f.contig && start_cyc != last_end + 1) bad++;
          for (int k = 0; k < nb * f.div; k++) begin
            if (k > 0) @(negedge clk);
            if (txd !== bits[k / f.div]) bad++;
          end
          prev_end = last_end;
          last_end = cyc;
          if (bad != 0) begin
            failures++;
            $display("FAIL frame_0x%02h got=%0d bad txd samples/gaps (start=%0d prev_end=%0d) required=0",
                     f.d, bad, start_cyc, prev_end);
          end
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    address = a;
    rd_exp.push_back(e);
    rd_name.push_back(n);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int div, input bit pe, input bit odd, input bit contig);
    frm_t f;
    f.d = d; f.div = div; f.par_en = pe; f.odd = odd; f.contig = contig;
    tx_q.push_back(f);
    wr(2'd0, {24'h0, d});
  endtask

  task automatic check_bit(input string n, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%b required=%b", n, got, req);
    end
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while (tx_q.size() != 0 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    repeat (120) @(negedge clk);
    checks++;
    if (tx_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d frames pending required=0", tag, tx_q.size());
    end
  endtask

  initial begin : stimulus
    int busy_n;
    reset_n = 1'b0; address = '0; write_n = 1'b1; writedata = '0; chipselect = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_txd", txd, 1'b1);
    check_bit("reset_irq", irq, 1'b0);
    checks++;
    if (readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_readdata got=0x%08h required=0x00000000", readdata);
    end
    reset_n = 1'b1;
    rd(2'd1, 32'h0000_0004, "status_after_reset");
    rd(2'd2, 32'd434, "div_after_reset");
    rd(2'd0, 32'h0, "data_reads_zero");
    rd(2'd3, 32'h0, "addr3_reads_zero");

    // Single 0x55 frame at DIV=4, busy observed via STATUS held on the bus.
    wr(2'd2, 32'd4);
    rd(2'd2, 32'd4, "div_readback_4");
    send(8'h55, 4, 1'b0, 1'b0, 1'b0);
    address = 2'd1;
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (readdata[0] === 1'b1) busy_n++;
    end
    checks++;
    if (busy_n != 40) begin
      failures++;
      $display("FAIL busy_cycles got=%0d required=40", busy_n);
    end
    rd(2'd1, 32'h0000_0004, "status_idle_after_frame");

    // Back-to-back frames and overflow: A5 is popped at once, four fill the FIFO, 0x99 is dropped.
    send(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 4, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 4, 1'b0, 1'b0, 1'b1);
    send(8'h00, 4, 1'b0, 1'b0, 1'b1);
    send(8'h81, 4, 1'b0, 1'b0, 1'b1);
    wr(2'd0, 32'h99);
    rd(2'd1, 32'h0000_040B, "status_full_overflow");
    wr(2'd1, 32'h8);
    rd(2'd1, 32'h0000_0403, "status_overflow_cleared");
    wait_drain("burst");

    // irq follows irq_en & empty with one cycle of register delay.
    wr(2'd1, 32'h10);
    @(negedge clk);
    check_bit("irq_idle_empty", irq, 1'b1);
    send(8'h5A, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_bit("irq_after_push", irq, 1'b0);
    @(negedge clk);
    check_bit("irq_after_pop", irq, 1'b1);
    wr(2'd1, 32'h0);
    wait_drain("irq");

    // Divisor clamp and mid-frame divisor change.
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd2, "div_clamp_1_to_2");
    wr(2'd2, 32'd4);
    send(8'h3C, 4, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    wr(2'd2, 32'd8);
    rd(2'd2, 32'd8, "div_readback_8");
    wait_drain("divchg");

    wr(2'd1, 32'h70);
`ifdef NIOS_RS232_TX_PARITY_EN
    rd(2'd1, 32'h0000_0074, "status_bits_5_6");
`else
    rd(2'd1, 32'h0000_0014, "status_bits_5_6_absent");
`endif
    wr(2'd1, 32'h0);

`ifdef NIOS_RS232_TX_PARITY_EN
    wr(2'd2, 32'd4);
    wr(2'd1, 32'h20);
    send(8'h07, 4, 1'b1, 1'b0, 1'b0);
    wait_drain("even_par");
    wr(2'd1, 32'h60);
    send(8'h07, 4, 1'b1, 1'b1, 1'b0);
    wait_drain("odd_par");
    rd(2'd1, 32'h0000_0064, "status_parity_odd");
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
